cpu_step_ctrl: RTL

Micro-step sequencer for the CPU control path. Owns the step counter that drives the instruction micro-sequence and adds start/halt/resume control, a programmable terminal step, optional auto-repeat and optional single-step gating. Sits between the debug/control inputs and the decode logic, which consumes `step_o` as the current micro-step index.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/cpu_step_counter.sv | 28 ++
 rtl/cpu_step_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control-path micro-step sequencer.
package cpu_pkg;

    localparam int unsigned CPU_STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } cpu_state_e;

endpackage

// File: rtl/cpu_step_counter.sv
// Micro-step index counter: synchronous clear beats enable, async active-low reset to 0.
module cpu_step_counter
    import cpu_pkg::*;
#(
    parameter int unsigned STEP_W = CPU_STEP_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [STEP_W-1:0] o_cnt
);

    logic [STEP_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + STEP_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Micro-step sequencer: start/halt/resume control, latched terminal step, auto-repeat.
// Optional single-step gating of RUN advance under CPU_STEP_CTRL_SINGLE_STEP_EN.
module cpu_step_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned STEP_W = CPU_STEP_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              halt_i,
    input  logic              repeat_i,
    input  logic [STEP_W-1:0] last_step_i,
    input  logic              step_mode_i,
    input  logic              step_i,
    output logic [STEP_W-1:0] step_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              done_o
);

    cpu_state_e        r_state;
    logic [STEP_W-1:0] r_last;
    logic              r_busy;
    logic              r_halted;
    logic              r_done;

    logic [STEP_W-1:0] w_step;
    logic              w_adv;
    logic              w_term;
    logic              w_go;
    logic              w_clr;
    logic              w_en;

`ifdef CPU_STEP_CTRL_SINGLE_STEP_EN
    assign w_adv = !step_mode_i || step_i;
`else
    logic w_unused_step;
    assign w_unused_step = step_mode_i ^ step_i;
    assign w_adv         = 1'b1;
`endif

    assign w_term = (w_step == r_last);
    assign w_go   = start_i && !halt_i;

    // Counter control: halt always freezes, terminal step wraps to 0.
    always_comb begin
        w_clr = 1'b0;
        w_en  = 1'b0;
        case (r_state)
            IDLE: w_clr = w_go;
            RUN: begin
                if (!halt_i && w_adv) begin
                    w_clr = w_term;
                    w_en  = !w_term;
                end
            end
            default: ;
        endcase
    end

    cpu_step_counter #(
        .STEP_W (STEP_W)
    ) u_counter (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_cnt   (w_step)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_last   <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_last  <= last_step_i;
                    end
                end
                RUN: begin
                    if (halt_i) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_adv && w_term) begin
                        r_done <= 1'b1;
                        if (!repeat_i) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (w_go) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign step_o   = w_step;
    assign busy_o   = r_busy;
    assign halted_o = r_halted;
    assign done_o   = r_done;

endmodule
